// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin codes, return-coin codes,
// nickel values and the controller state encoding.
package vend_pkg;

  typedef enum logic [2:0] {
    COIN_NICKEL  = 3'd0,
    COIN_DIME    = 3'd1,
    COIN_QUARTER = 3'd2,
    COIN_FIFTY   = 3'd3,
    COIN_DOLLAR  = 3'd4,
    COIN_FIVE    = 3'd5
  } coin_type_e;

  typedef enum logic [1:0] {
    RET_NICKEL  = 2'd0,
    RET_DIME    = 2'd1,
    RET_QUARTER = 2'd2,
    RET_DOLLAR  = 2'd3
  } ret_coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  localparam int unsigned VAL_NICKEL  = 1;
  localparam int unsigned VAL_DIME    = 2;
  localparam int unsigned VAL_QUARTER = 5;
  localparam int unsigned VAL_FIFTY   = 10;
  localparam int unsigned VAL_DOLLAR  = 20;
  localparam int unsigned VAL_FIVE    = 100;

  function automatic logic coin_legal(input logic [2:0] t);
    return t <= 3'd5;
  endfunction

  function automatic logic [6:0] coin_value(input logic [2:0] t);
    case (t)
      COIN_NICKEL:  return 7'(VAL_NICKEL);
      COIN_DIME:    return 7'(VAL_DIME);
      COIN_QUARTER: return 7'(VAL_QUARTER);
      COIN_FIFTY:   return 7'(VAL_FIFTY);
      COIN_DOLLAR:  return 7'(VAL_DOLLAR);
      COIN_FIVE:    return 7'(VAL_FIVE);
      default:      return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Holds outstanding change and pays it out greedily, one coin per accepted handshake.
// done_o pulses on the handshake that empties the register.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] amount_i,
  input  logic         ret_ready_i,
  output logic         ret_valid_o,
  output logic [1:0]   ret_coin_o,
  output logic         done_o
);

  logic [W-1:0] change_q, change_d, coin_val;

  always_comb begin
    ret_coin_o = RET_NICKEL;
    coin_val   = W'(VAL_NICKEL);
    if (change_q >= W'(VAL_DOLLAR)) begin
      ret_coin_o = RET_DOLLAR;
      coin_val   = W'(VAL_DOLLAR);
    end else if (change_q >= W'(VAL_QUARTER)) begin
      ret_coin_o = RET_QUARTER;
      coin_val   = W'(VAL_QUARTER);
    end else if (change_q >= W'(VAL_DIME)) begin
      ret_coin_o = RET_DIME;
      coin_val   = W'(VAL_DIME);
    end

    ret_valid_o = change_q != '0;
    done_o      = ret_valid_o && ret_ready_i && (change_q == coin_val);

    change_d = change_q;
    if (load_i) begin
      change_d = amount_i;
    end else if (ret_valid_o && ret_ready_i) begin
      change_d = change_q - coin_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change_q <= '0;
    end else begin
      change_q <= change_d;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: per-slot price/stock tables, credit accumulation and selection.
// Change and refunds drain through change_dispenser one coin per cycle.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 9,
  parameter int unsigned PRICE_W    = 8,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned MAX_CREDIT = 100,
  parameter logic [NUM_SLOTS*PRICE_W-1:0] INIT_PRICE = '0,
  parameter logic [STOCK_W-1:0]           INIT_STOCK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [2:0]                   coin_type,
  output logic                         coin_ready,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] sel_idx,
  input  logic                         cancel,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
  input  logic [PRICE_W-1:0]           cfg_price,
  input  logic [STOCK_W-1:0]           cfg_stock,
  output logic                         cfg_err,
  output logic                         vend_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] vend_idx,
  output logic                         sel_denied,
  output logic                         ret_valid,
  output logic [1:0]                   ret_coin,
  input  logic                         ret_ready,
  output logic [PRICE_W-1:0]           credit,
  output logic [NUM_SLOTS-1:0]         green_led,
  output logic [NUM_SLOTS-1:0]         red_led
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

  state_e             state_q, state_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic [PRICE_W-1:0] price_q [NUM_SLOTS];
  logic [PRICE_W-1:0] price_d [NUM_SLOTS];
  logic [STOCK_W-1:0] stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0] stock_d [NUM_SLOTS];
  logic               vend_valid_q, vend_valid_d;
  logic               sel_denied_q, sel_denied_d;
  logic               cfg_err_q, cfg_err_d;
  logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;

  logic               chg_load, chg_done;
  logic [PRICE_W-1:0] chg_amount, coin_val, sel_price;
  logic [STOCK_W-1:0] sel_stock;
  logic [PRICE_W:0]   credit_sum;
  logic               sel_hit, sel_ok, cfg_hit;

  // Index decode by comparison so out-of-range indices never touch the tables.
  always_comb begin
    sel_hit   = 1'b0;
    cfg_hit   = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_hit   = 1'b1;
        sel_price = price_q[i];
        sel_stock = stock_q[i];
      end
      if (cfg_idx == IDX_W'(i)) cfg_hit = 1'b1;
    end
    sel_ok     = sel_hit && (sel_price != '0) && (sel_stock != '0) && (credit_q >= sel_price);
    coin_val   = PRICE_W'(coin_value(coin_type));
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ready = (state_q != ST_CHANGE) && !cancel && !sel_valid;
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    price_d      = price_q;
    stock_d      = stock_q;
    vend_valid_d = 1'b0;
    vend_idx_d   = vend_idx_q;
    sel_denied_d = 1'b0;
    cfg_err_d    = 1'b0;
    chg_load     = 1'b0;
    chg_amount   = '0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          if (state_q == ST_CREDIT) begin
            chg_load   = 1'b1;
            chg_amount = credit_q;
            credit_d   = '0;
            state_d    = ST_CHANGE;
          end
        end else if (sel_valid) begin
          if (sel_ok) begin
            vend_valid_d = 1'b1;
            vend_idx_d   = sel_idx;
            credit_d     = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (sel_idx == IDX_W'(i) && stock_q[i] != '0) stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            if (credit_q != sel_price) begin
              chg_load   = 1'b1;
              chg_amount = credit_q - sel_price;
              state_d    = ST_CHANGE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sel_denied_d = 1'b1;
          end
        end else if (coin_valid && coin_legal(coin_type)) begin
          if (credit_sum <= (PRICE_W+1)'(MAX_CREDIT)) begin
            credit_d = credit_sum[PRICE_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            chg_load   = 1'b1;
            chg_amount = coin_val;
            state_d    = ST_CHANGE;
          end
        end
      end
      ST_CHANGE: begin
        if (chg_done) state_d = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_we) begin
      if (state_q == ST_IDLE && cfg_hit) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            price_d[i] = cfg_price;
            stock_d[i] = cfg_stock;
          end
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      credit_q     <= '0;
      vend_valid_q <= 1'b0;
      vend_idx_q   <= '0;
      sel_denied_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price_q[i] <= INIT_PRICE[i*PRICE_W +: PRICE_W];
        stock_q[i] <= INIT_STOCK;
      end
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      vend_valid_q <= vend_valid_d;
      vend_idx_q   <= vend_idx_d;
      sel_denied_q <= sel_denied_d;
      cfg_err_q    <= cfg_err_d;
      price_q      <= price_d;
      stock_q      <= stock_d;
    end
  end

  change_dispenser #(.W(PRICE_W)) u_change (
    .clk         (clk),
    .rst         (rst),
    .load_i      (chg_load),
    .amount_i    (chg_amount),
    .ret_ready_i (ret_ready),
    .ret_valid_o (ret_valid),
    .ret_coin_o  (ret_coin),
    .done_o      (chg_done)
  );

  always_comb begin
    green_led = '0;
    red_led   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      red_led[i]   = (price_q[i] == '0) || (stock_q[i] == '0);
      green_led[i] = !red_led[i] && (credit_q >= price_q[i]);
    end
  end

  assign credit     = credit_q;
  assign vend_valid = vend_valid_q;
  assign vend_idx   = vend_idx_q;
  assign sel_denied = sel_denied_q;
  assign cfg_err    = cfg_err_q;

endmodule
